// File: rtl/sev_seg_scan_disp.sv
// Multi-digit seven-segment driver: one-bit-per-clock double-dabble BCD conversion of a
// loaded value, shown on a scanned common-anode display; result lands WIDTH+1 cycles after load.
module sev_seg_scan_disp #(
  parameter int WIDTH    = 10,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WIDTH-1:0]  value,
  output logic              busy,
  output logic              done,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);
  localparam int NIB = DIGITS + 1;
  localparam int BW  = 4 * NIB;
  localparam int CW  = $clog2(WIDTH + 1);
  localparam int PW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] LIMIT = pow10(DIGITS);

  function automatic logic [6:0] segCode(input logic [3:0] d);
    case (d)
      4'd0:    segCode = 7'd64;
      4'd1:    segCode = 7'd121;
      4'd2:    segCode = 7'd36;
      4'd3:    segCode = 7'd48;
      4'd4:    segCode = 7'd25;
      4'd5:    segCode = 7'd18;
      4'd6:    segCode = 7'd2;
      4'd7:    segCode = 7'd120;
      4'd8:    segCode = 7'd0;
      4'd9:    segCode = 7'd16;
      default: segCode = 7'd127;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t              state;
  logic [WIDTH-1:0]    binReg;
  logic [BW-1:0]       bcdReg;
  logic [BW-1:0]       bcdAdj;
  logic [CW-1:0]       bitCnt;
  logic                ovfWork;
  logic                ovfDisp;
  logic [4*DIGITS-1:0] dispBcd;
  logic [PW-1:0]       prescale;
  logic [IW-1:0]       index;
  logic [3:0]          curNib;
  logic                blank;

  // Add-3 correction applied to every nibble before the shift.
  always_comb begin
    bcdAdj = bcdReg;
    for (int i = 0; i < NIB; i++)
      if (bcdReg[4*i +: 4] >= 4'd5) bcdAdj[4*i +: 4] = bcdReg[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      binReg  <= '0;
      bcdReg  <= '0;
      bitCnt  <= '0;
      ovfWork <= 1'b0;
      ovfDisp <= 1'b0;
      dispBcd <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (load) begin
          binReg  <= value;
          bcdReg  <= '0;
          bitCnt  <= CW'(WIDTH);
          ovfWork <= (64'(value) >= LIMIT);
          busy    <= 1'b1;
          state   <= SHIFT;
        end
        SHIFT: begin
          bcdReg <= {bcdAdj[BW-2:0], binReg[WIDTH-1]};
          binReg <= binReg << 1;
          bitCnt <= bitCnt - CW'(1);
          if (bitCnt == CW'(1)) state <= LATCH;
        end
        LATCH: begin
          dispBcd <= bcdReg[4*DIGITS-1:0];
          ovfDisp <= ovfWork;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescale <= '0;
      index    <= '0;
    end else if (prescale == PW'(SCAN_DIV - 1)) begin
      prescale <= '0;
      index    <= (index == IW'(DIGITS - 1)) ? '0 : index + IW'(1);
    end else begin
      prescale <= prescale + PW'(1);
    end
  end

  // A digit is blank when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    curNib = dispBcd[4*int'(index) +: 4];
    blank  = (index != '0);
    for (int j = 0; j < DIGITS; j++)
      if (j >= int'(index) && dispBcd[4*j +: 4] != 4'd0) blank = 1'b0;
    an = ~(DIGITS'(1) << index);
    if (ovfDisp)    seg = 7'd63;
    else if (blank) seg = 7'd127;
    else            seg = segCode(curNib);
  end
endmodule

// File: tb/tb_sev_seg_scan_disp.sv
// Bench for sev_seg_scan_disp: two instances (4 and 2 digits, SCAN_DIV=4) checked against
// a decimal-arithmetic display model and a cycle counter that tracks the scan position.
module tb_sev_seg_scan_disp;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       loadA = 1'b0, loadB = 1'b0;
  logic [9:0] valA = '0, valB = '0;
  logic       busyA, doneA, busyB, doneB;
  logic [6:0] segA, segB;
  logic [3:0] anA;
  logic [1:0] anB;
  int         checks = 0, failures = 0;
  int         cyc;
  int         dispA = 0, dispB = 0;

  // Negedge index (counted from the accepting edge) at which done is first visible.
  localparam int DONE_C = 12;

  logic [6:0] segTab [0:9] = '{7'd64, 7'd121, 7'd36, 7'd48, 7'd25, 7'd18, 7'd2, 7'd120, 7'd0, 7'd16};

  sev_seg_scan_disp #(.WIDTH(10), .DIGITS(4), .SCAN_DIV(4)) dutA (
    .clk(clk), .reset(reset), .load(loadA), .value(valA),
    .busy(busyA), .done(doneA), .seg(segA), .an(anA));

  sev_seg_scan_disp #(.WIDTH(10), .DIGITS(2), .SCAN_DIV(4)) dutB (
    .clk(clk), .reset(reset), .load(loadB), .value(valB),
    .busy(busyB), .done(doneB), .seg(segB), .an(anB));

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  function automatic logic [6:0] expSeg(int v, int d, int n);
    int lim = 1;
    int p = 1;
    for (int i = 0; i < n; i++) lim *= 10;
    for (int i = 0; i < d; i++) p *= 10;
    if (v >= lim) return 7'd63;
    if (d > 0 && v < p) return 7'd127;
    return segTab[(v / p) % 10];
  endfunction

  function automatic int curDigit(int n);
    return (cyc / 4) % n;
  endfunction

  function automatic logic [7:0] expAn(int n);
    return ~(8'd1 << curDigit(n));
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busyA !== 1'b0 || doneA !== 1'b0 || busyB !== 1'b0 || doneB !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags busy=%b%b done=%b%b expected 0000", busyA, busyB, doneA, doneB);
    end
    checks++;
    if (anA !== 4'b1110 || segA !== 7'd64) begin
      failures++;
      $display("FAIL reset_disp an=%b seg=%0d expected an=1110 seg=64", anA, segA);
    end
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (anA !== 4'(expAn(4)) || segA !== expSeg(0, curDigit(4), 4)) begin
        failures++;
        $display("FAIL reset_scan i=%0d an=%b seg=%0d expected an=%b seg=%0d",
                 i, anA, segA, 4'(expAn(4)), expSeg(0, curDigit(4), 4));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_scan_wrap();
    int start;
    int guard = 0;
    logic [3:0] e;
    while (cyc % 4 != 0 && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    start = curDigit(4);
    for (int k = 0; k < 5; k++)
      for (int c = 0; c < 4; c++) begin
        e = ~(4'b0001 << ((start + k) % 4));
        checks++;
        if (anA !== e) begin
          failures++;
          $display("FAIL scan_wrap k=%0d c=%0d an=%b expected %b", k, c, anA, e);
        end
        @(negedge clk);
      end
  endtask

  task automatic test_load88();
    valA = 10'd88;
    loadA = 1'b1;
    @(negedge clk);
    loadA = 1'b0;
    for (int c = 1; c <= DONE_C; c++) begin
      if (c < DONE_C) begin
        checks++;
        if (doneA !== 1'b0 || busyA !== 1'b1) begin
          failures++;
          $display("FAIL load88_busy c=%0d busy=%b done=%b expected busy=1 done=0", c, busyA, doneA);
        end
        checks++;
        if (segA !== expSeg(dispA, curDigit(4), 4)) begin
          failures++;
          $display("FAIL load88_hold c=%0d seg=%0d expected %0d", c, segA, expSeg(dispA, curDigit(4), 4));
        end
        @(negedge clk);
      end else begin
        checks++;
        if (doneA !== 1'b1 || busyA !== 1'b0) begin
          failures++;
          $display("FAIL load88_done busy=%b done=%b expected busy=0 done=1", busyA, doneA);
        end
      end
    end
    dispA = 88;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (anA !== 4'(expAn(4)) || segA !== expSeg(dispA, curDigit(4), 4)) begin
        failures++;
        $display("FAIL load88_disp i=%0d an=%b seg=%0d expected an=%b seg=%0d",
                 i, anA, segA, 4'(expAn(4)), expSeg(dispA, curDigit(4), 4));
      end
      if (i > 0) begin
        checks++;
        if (doneA !== 1'b0) begin
          failures++;
          $display("FAIL load88_pulse i=%0d done=%b expected 0", i, doneA);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int doneAt = -1;
    valA = 10'd500;
    loadA = 1'b1;
    @(negedge clk);
    loadA = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (doneA === 1'b1) begin
        doneAt = c;
        break;
      end
      if (c == 2) valA = 10'd7;
      loadA = (c == 2);
      @(negedge clk);
    end
    loadA = 1'b0;
    checks++;
    if (doneAt != DONE_C) begin
      failures++;
      $display("FAIL b2b_ignore done_at=%0d expected %0d", doneAt, DONE_C);
    end
    dispA = 500;
    checks++;
    if (segA !== expSeg(dispA, curDigit(4), 4) || busyA !== 1'b0) begin
      failures++;
      $display("FAIL b2b_500 seg=%0d busy=%b expected seg=%0d busy=0", segA, busyA, expSeg(dispA, curDigit(4), 4));
    end
    valA = 10'd1023;
    loadA = 1'b1;
    @(negedge clk);
    loadA = 1'b0;
    doneAt = -1;
    for (int c = 1; c <= 30; c++) begin
      if (doneA === 1'b1) begin
        doneAt = c;
        break;
      end
      checks++;
      if (segA !== expSeg(dispA, curDigit(4), 4)) begin
        failures++;
        $display("FAIL b2b_hold500 c=%0d seg=%0d expected %0d", c, segA, expSeg(dispA, curDigit(4), 4));
      end
      @(negedge clk);
    end
    checks++;
    if (doneAt != DONE_C) begin
      failures++;
      $display("FAIL b2b_next done_at=%0d expected %0d", doneAt, DONE_C);
    end
    dispA = 1023;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (anA !== 4'(expAn(4)) || segA !== expSeg(dispA, curDigit(4), 4)) begin
        failures++;
        $display("FAIL b2b_1023 i=%0d an=%b seg=%0d expected an=%b seg=%0d",
                 i, anA, segA, 4'(expAn(4)), expSeg(dispA, curDigit(4), 4));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_digits2();
    int vals [3] = '{100, 99, 0};
    int doneAt;
    for (int n = 0; n < 3; n++) begin
      valB = 10'(vals[n]);
      loadB = 1'b1;
      @(negedge clk);
      loadB = 1'b0;
      doneAt = -1;
      for (int c = 1; c <= 30; c++) begin
        if (doneB === 1'b1) begin
          doneAt = c;
          break;
        end
        @(negedge clk);
      end
      checks++;
      if (doneAt != DONE_C) begin
        failures++;
        $display("FAIL d2_done v=%0d done_at=%0d expected %0d", vals[n], doneAt, DONE_C);
      end
      dispB = vals[n];
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (anB !== 2'(expAn(2)) || segB !== expSeg(dispB, curDigit(2), 2)) begin
          failures++;
          $display("FAIL d2_disp v=%0d i=%0d an=%b seg=%0d expected an=%b seg=%0d",
                   dispB, i, anB, segB, 2'(expAn(2)), expSeg(dispB, curDigit(2), 2));
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_random();
    int v, nd, doneAt;
    bit sel;
    logic [6:0] s;
    logic [3:0] a, ea;
    for (int n = 0; n < 10; n++) begin
      sel = n[0];
      v = sel ? int'($urandom_range(0, 200)) : int'($urandom_range(0, 1023));
      if (sel) begin valB = 10'(v); loadB = 1'b1; end
      else     begin valA = 10'(v); loadA = 1'b1; end
      @(negedge clk);
      loadA = 1'b0;
      loadB = 1'b0;
      doneAt = -1;
      for (int c = 1; c <= 30; c++) begin
        if ((sel ? doneB : doneA) === 1'b1) begin
          doneAt = c;
          break;
        end
        @(negedge clk);
      end
      checks++;
      if (doneAt != DONE_C) begin
        failures++;
        $display("FAIL rand_done sel=%0d v=%0d done_at=%0d expected %0d", sel, v, doneAt, DONE_C);
      end
      if (sel) dispB = v; else dispA = v;
      nd = sel ? 2 : 4;
      for (int i = 0; i < 4 * nd; i++) begin
        s  = sel ? segB : segA;
        a  = sel ? {2'b11, anB} : anA;
        ea = sel ? {2'b11, 2'(expAn(2))} : 4'(expAn(4));
        checks++;
        if (a !== ea || s !== expSeg(v, curDigit(nd), nd)) begin
          failures++;
          $display("FAIL rand_disp sel=%0d v=%0d i=%0d an=%b seg=%0d expected an=%b seg=%0d",
                   sel, v, i, a, s, ea, expSeg(v, curDigit(nd), nd));
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset_mid();
    valA = 10'd1000;
    loadA = 1'b1;
    @(negedge clk);
    loadA = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (busyA !== 1'b0 || doneA !== 1'b0) begin
      failures++;
      $display("FAIL midrst_flags busy=%b done=%b expected 0 0", busyA, doneA);
    end
    checks++;
    if (anA !== 4'b1110 || segA !== 7'd64) begin
      failures++;
      $display("FAIL midrst_disp an=%b seg=%0d expected an=1110 seg=64", anA, segA);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    dispA = 0;
    dispB = 0;
    for (int i = 0; i < 30; i++) begin
      checks++;
      if (doneA !== 1'b0 || busyA !== 1'b0) begin
        failures++;
        $display("FAIL midrst_nodone i=%0d busy=%b done=%b expected 0 0", i, busyA, doneA);
      end
      checks++;
      if (anA !== 4'(expAn(4)) || segA !== expSeg(dispA, curDigit(4), 4)) begin
        failures++;
        $display("FAIL midrst_scan i=%0d an=%b seg=%0d expected an=%b seg=%0d",
                 i, anA, segA, 4'(expAn(4)), expSeg(dispA, curDigit(4), 4));
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_scan_wrap();
    test_load88();
    test_back_to_back();
    test_digits2();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
